// File: rtl/exec_core_if.sv
// exec_core_if: operation, external register load and result signals of exec_core.
// The core takes the slave modport; the driver of operations takes master.
interface exec_core_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16
);
    localparam int AW = $clog2(NUM_REGS);
    logic              op_valid;
    logic              op_ready;
    logic [3:0]        op_code;
    logic [AW-1:0]     rs1;
    logic [AW-1:0]     rs2;
    logic [AW-1:0]     rd;
    logic              ext_we;
    logic [AW-1:0]     ext_waddr;
    logic [DATA_W-1:0] ext_wdata;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic [AW-1:0]     res_rd;
    logic              res_zero;
    logic              busy;
    modport master (
        output op_valid, op_code, rs1, rs2, rd, ext_we, ext_waddr, ext_wdata,
        input  op_ready, res_valid, res_data, res_rd, res_zero, busy
    );
    modport slave (
        input  op_valid, op_code, rs1, rs2, rd, ext_we, ext_waddr, ext_wdata,
        output op_ready, res_valid, res_data, res_rd, res_zero, busy
    );
endinterface

// File: rtl/exec_core.sv
// exec_core: register file plus single-cycle ALU with registered result and zero flag.
// Define EXEC_CORE_MUL_EN to make opcode B an iterative shift-add multiply.
module exec_core #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16
) (
    input logic         clk,
    input logic         reset,
    exec_core_if.slave  bus
);
    localparam int AW = $clog2(NUM_REGS);
    localparam logic [DATA_W-1:0] DW = DATA_W'(DATA_W);
    logic [DATA_W-1:0] regFile [NUM_REGS];
    logic              rstDone;
    logic              fire;
    logic              wbWe;
    logic [AW-1:0]     wbAddr;
    logic [DATA_W-1:0] wbData;
    logic [DATA_W-1:0] opA, opB, shamt, aluOut;
    // An external load landing at this edge is bypassed into the operands.
    assign opA = (bus.ext_we && bus.ext_waddr == bus.rs1 && bus.rs1 != '0) ? bus.ext_wdata : regFile[bus.rs1];
    assign opB = (bus.ext_we && bus.ext_waddr == bus.rs2 && bus.rs2 != '0) ? bus.ext_wdata : regFile[bus.rs2];
    assign shamt = opB % DW;
    assign fire = bus.op_valid && bus.op_ready;
    always_comb begin
        aluOut = '0;
        case (bus.op_code)
            4'h0: aluOut = opA + opB;
            4'h1: aluOut = opA - opB;
            4'h2: aluOut = opA & opB;
            4'h3: aluOut = opA | opB;
            4'h4: aluOut = opA ^ opB;
            4'h5: aluOut = opA << shamt;
            4'h6: aluOut = opA >> shamt;
            4'h7: aluOut = $signed(opA) >>> shamt;
            4'h8: aluOut = DATA_W'($signed(opA) < $signed(opB));
            4'h9: aluOut = DATA_W'(opA < opB);
            4'hA: aluOut = opA;
            default: aluOut = '0;
        endcase
    end
`ifdef EXEC_CORE_MUL_EN
    localparam int CW = $clog2(DATA_W);
    typedef enum logic {IDLE, MUL} coreState;
    coreState          state, stateNext;
    logic [CW-1:0]     mulCnt;
    logic [AW-1:0]     mulRd;
    logic [DATA_W-1:0] mulAcc, mulCand, mulPlier, mulSum;
    logic              mulStart, mulDone;
    assign mulStart = fire && bus.op_code == 4'hB;
    assign mulDone  = state == MUL && mulCnt == CW'(DATA_W - 1);
    assign mulSum   = mulAcc + (mulPlier[0] ? mulCand : '0);
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= stateNext;
    always_comb begin
        stateNext    = mulStart ? MUL : mulDone ? IDLE : state;
        bus.op_ready = rstDone && state == IDLE;
        bus.busy     = state == MUL;
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            mulCnt   <= '0;
            mulRd    <= '0;
            mulAcc   <= '0;
            mulCand  <= '0;
            mulPlier <= '0;
        end else if (mulStart) begin
            mulCnt   <= '0;
            mulRd    <= bus.rd;
            mulAcc   <= '0;
            mulCand  <= opA;
            mulPlier <= opB;
        end else if (state == MUL) begin
            mulCnt   <= mulCnt + 1'b1;
            mulAcc   <= mulSum;
            mulCand  <= mulCand << 1;
            mulPlier <= mulPlier >> 1;
        end
    assign wbWe   = (fire && !mulStart) || mulDone;
    assign wbAddr = mulDone ? mulRd : bus.rd;
    assign wbData = mulDone ? mulSum : aluOut;
`else
    assign bus.op_ready = rstDone;
    assign bus.busy     = 1'b0;
    assign wbWe         = fire;
    assign wbAddr       = bus.rd;
    assign wbData       = aluOut;
`endif
    // Register 0 is never written, so it keeps reading zero.
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) regFile[i] <= '0;
            rstDone       <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
            bus.res_rd    <= '0;
            bus.res_zero  <= 1'b0;
        end else begin
            rstDone       <= 1'b1;
            bus.res_valid <= wbWe;
            for (int i = 1; i < NUM_REGS; i++)
                if (wbWe && wbAddr == AW'(i)) regFile[i] <= wbData;
                else if (bus.ext_we && bus.ext_waddr == AW'(i)) regFile[i] <= bus.ext_wdata;
            if (wbWe) begin
                bus.res_data <= wbData;
                bus.res_rd   <= wbAddr;
                bus.res_zero <= wbData == '0;
            end
        end
endmodule

// File: tb/tb_exec_core.sv
// tb_exec_core: directed operations with a result scoreboard checked by a monitor.
module tb_exec_core;
    localparam int DW = 32;
    localparam int NR = 16;
    localparam int AW = 4;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;
    exec_core_if #(.DATA_W(DW), .NUM_REGS(NR)) bus ();
    exec_core #(.DATA_W(DW), .NUM_REGS(NR)) dut (.clk(clk), .reset(reset), .bus(bus));
    typedef struct {
        logic [DW-1:0] d;
        logic [AW-1:0] r;
    } expT;
    expT sb[$];
    int nCmp = 0;
    int nBad = 0;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        nCmp++;
        if (act !== req) begin
            nBad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask
    always @(negedge clk)
        if (reset && bus.res_valid) begin
            expT e;
            if (sb.size() == 0) check("unexpected res_valid", 64'(bus.res_valid), 64'd0);
            else begin
                e = sb.pop_front();
                check("res_data", 64'(bus.res_data), 64'(e.d));
                check("res_rd", 64'(bus.res_rd), 64'(e.r));
                check("res_zero", 64'(bus.res_zero), 64'(e.d == '0));
            end
        end
    task automatic extSet(input int a, input logic [DW-1:0] v);
        bus.ext_we = 1'b1;
        bus.ext_waddr = AW'(a);
        bus.ext_wdata = v;
    endtask
    task automatic extW(input int a, input logic [DW-1:0] v);
        extSet(a, v);
        @(posedge clk);
        #1 bus.ext_we = 1'b0;
    endtask
    task automatic issue(input logic [3:0] code, input int a, input int b, input int rd,
                         input logic [DW-1:0] req, input bit push = 1'b1);
        check("op_ready at issue", 64'(bus.op_ready), 64'd1);
        bus.op_valid = 1'b1;
        bus.op_code = code;
        bus.rs1 = AW'(a);
        bus.rs2 = AW'(b);
        bus.rd = AW'(rd);
        if (push) sb.push_back('{d: req, r: AW'(rd)});
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        bus.ext_we = 1'b0;
    endtask
    initial begin
        int cnt;
        bus.op_valid = 1'b0;
        bus.op_code = '0;
        bus.rs1 = '0;
        bus.rs2 = '0;
        bus.rd = '0;
        bus.ext_we = 1'b0;
        bus.ext_waddr = '0;
        bus.ext_wdata = '0;
        repeat (3) @(negedge clk);
        check("reset op_ready", 64'(bus.op_ready), 64'd0);
        check("reset res_valid", 64'(bus.res_valid), 64'd0);
        check("reset res_data", 64'(bus.res_data), 64'd0);
        check("reset res_rd", 64'(bus.res_rd), 64'd0);
        check("reset res_zero", 64'(bus.res_zero), 64'd0);
        check("reset busy", 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 check("op_ready after release", 64'(bus.op_ready), 64'd1);
        extW(1, 5);
        extW(2, 3);
        issue(4'h0, 1, 2, 4, 8);
        issue(4'h1, 2, 1, 5, 32'hFFFF_FFFE);
        issue(4'h2, 1, 2, 6, 1);
        issue(4'h3, 1, 2, 7, 7);
        issue(4'h4, 1, 2, 6, 6);
        extW(2, 33);
        extSet(1, 32'h8000_0000);
        issue(4'h7, 1, 2, 8, 32'hC000_0000);
        issue(4'h6, 1, 2, 10, 32'h4000_0000);
        issue(4'h5, 1, 2, 11, 32'h0);
        extW(2, 1);
        issue(4'h8, 1, 2, 9, 1);
        issue(4'h9, 1, 2, 11, 0);
        extW(1, 5);
        extW(2, 3);
        issue(4'h0, 1, 2, 3, 8);
        issue(4'h1, 3, 3, 5, 0);
        issue(4'hA, 3, 0, 13, 8);
        issue(4'hC, 1, 2, 12, 0);
        issue(4'hF, 1, 2, 12, 0);
        extSet(6, 32'hAA);
        issue(4'h0, 1, 2, 6, 8);
        extSet(7, 32'hAA);
        issue(4'h0, 1, 2, 14, 8);
        issue(4'hA, 6, 0, 15, 8);
        issue(4'hA, 7, 0, 15, 32'hAA);
        extW(0, 32'h55);
        issue(4'hA, 0, 0, 15, 0);
        issue(4'h0, 1, 2, 0, 8);
        issue(4'hA, 0, 0, 15, 0);
`ifdef EXEC_CORE_MUL_EN
        extW(1, 7);
        extW(2, 6);
        issue(4'hB, 1, 2, 13, 42);
        check("busy in MUL", 64'(bus.busy), 64'd1);
        cnt = 0;
        while (!bus.op_ready && cnt < 100) begin
            cnt++;
            @(posedge clk);
            #1;
        end
        check("MUL op_ready low cycles", 64'(cnt), 64'd32);
        @(posedge clk);
        #1 issue(4'hA, 13, 0, 15, 42);
        issue(4'hB, 1, 2, 14, 0, 1'b0);
        repeat (10) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("abort busy", 64'(bus.busy), 64'd0);
        check("abort res_valid", 64'(bus.res_valid), 64'd0);
        check("abort op_ready", 64'(bus.op_ready), 64'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (40) @(posedge clk);
        #1 issue(4'hA, 14, 0, 15, 0);
        issue(4'hA, 1, 0, 15, 0);
`else
        issue(4'hB, 1, 2, 12, 0);
        check("busy tied low", 64'(bus.busy), 64'd0);
`endif
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        #1 check("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule

// File: doc/exec_core.md
EXEC_CORE -- requirements
Module: exec_core

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning datapath and register width (8..64).
REQ-002 SHALL have parameter NUM_REGS, default 16, meaning register count (power of two, 2..64); AW = log2(NUM_REGS).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port op_valid  input  1  operation request.
REQ-006 SHALL have port op_ready  output  1  core can accept an operation this cycle.
REQ-007 SHALL have port op_code  input  4  ALU operation select.
REQ-008 SHALL have ports rs1, rs2, rd  input  AW each  source and destination register indices.
REQ-009 SHALL have ports ext_we (input, 1), ext_waddr (input, AW), ext_wdata (input, DATA_W)  external register load port.
REQ-010 SHALL have ports res_valid (output, 1), res_data (output, DATA_W), res_rd (output, AW), res_zero (output, 1)  registered result, destination and zero flag.
REQ-011 SHALL have port busy  output  1  multi-cycle operation in progress.

Function
REQ-012 An operation SHALL be accepted when op_valid and op_ready are both high on a rising edge; op_valid while op_ready is low SHALL be ignored.
REQ-013 Register 0 SHALL read as zero; writes to it SHALL be discarded.
REQ-014 Opcodes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed, result 0/1), 9 SLTU, A PASS rs1; B MUL per REQ-025/026; C-F reserved, result 0.
REQ-015 Shift amount SHALL be rs2 value modulo DATA_W; ADD/SUB SHALL wrap modulo 2^DATA_W.
REQ-016 Single-cycle ops SHALL have latency 1: accepted at edge N, res_valid high for exactly the cycle after edge N, with rd written at the same edge.
REQ-017 res_zero SHALL be high when the registered result equals zero; res_data, res_rd and res_zero SHALL hold their last values while res_valid is low.
REQ-018 Operand reads SHALL forward: a source equal to the rd written at the current edge (ALU or external) SHALL see the new value, so back-to-back dependent ops produce correct results.
REQ-019 ALU writeback and ext_we in the same cycle to different registers SHALL both take effect; to the same register, ALU writeback SHALL win.
REQ-020 State machine SHALL have states IDLE and MUL; IDLE: op_ready=1, busy=0; single-cycle ops stay in IDLE.
REQ-021 ext_we SHALL be honoured in any state, including MUL.

Reset
REQ-022 While reset is low, all registers SHALL be 0, state SHALL be IDLE, res_valid=0, res_data=0, res_rd=0, res_zero=0, busy=0.
REQ-023 op_ready SHALL be 0 while reset is low and 1 from the first edge after release.
REQ-024 Reset asserted during MUL SHALL abort the operation with no writeback and no res_valid.

Configuration
REQ-025 With macro EXEC_CORE_MUL_EN defined, opcode B SHALL be an iterative shift-add multiply: accepted in IDLE, enter MUL, op_ready=0 and busy=1 for DATA_W cycles, then writeback of the low DATA_W product bits with res_valid high for one cycle, return to IDLE; operands SHALL be captured at acceptance.
REQ-026 Without EXEC_CORE_MUL_EN, opcode B SHALL behave as reserved (single-cycle, result 0), the MUL state SHALL not exist and busy SHALL be tied 0.

Verification
REQ-027 Reset low, then high; ext load r1=5, r2=3; ADD rd=4 -> next cycle res_valid=1, res_data=8, res_rd=4, res_zero=0.
REQ-028 r1=0x80000000 (DATA_W=32): SRA by r2=33 -> 0xC0000000; SLT r1,r2(=1) -> 1; SLTU -> 0.
REQ-029 Back-to-back ADD r3=r1+r2 then SUB r5=r3-r3 -> second result 0, res_zero=1, no stall.
REQ-030 Same cycle ALU writeback to r6 and ext_we to r6 with 0xAA -> r6 holds ALU result; ext_we to r7 same cycle -> r7=0xAA.
REQ-031 With EXEC_CORE_MUL_EN: MUL 7*6 -> op_ready low 32 cycles, then res_data=42; repeat with reset pulsed mid-MUL -> no res_valid, rd unchanged (zero after reset).
